// File: rtl/mmio_responder_if.sv
// rtl/mmio_responder_if.sv - request/response bus between a requester and mmio_responder
// Signals:
//   address      byte address of the request (requester drives)
//   input_data   store data (requester drives)
//   mem_read     load request (requester drives)
//   mem_write    store request (requester drives)
//   output_data  load data, non-zero only while the responder is in DONE (responder drives)
//   stall        requester must hold its request stable while high (responder drives)
//   hit          address falls inside the 64-byte peripheral window (responder drives)
interface mmio_responder_if;
    logic [31:0] address;
    logic [31:0] input_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] output_data;
    logic        stall;
    logic        hit;

    modport master (
        output address,
        output input_data,
        output mem_read,
        output mem_write,
        input  output_data,
        input  stall,
        input  hit
    );

    modport slave (
        input  address,
        input  input_data,
        input  mem_read,
        input  mem_write,
        output output_data,
        output stall,
        output hit
    );
endinterface

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - memory-mapped LED / light-sensor / cycle-counter / scratch peripheral
// Ports:
//   clock     single clock, all state on rising edge
//   reset     synchronous, active-high, overrides every other input
//   bus       mmio_responder_if.slave: address, input_data, mem_read, mem_write in;
//             output_data, stall, hit out
//   photores  asynchronous 2-bit light-sensor input, synchronized and debounced
//   led       active-low LED drive, the inverse of the LED register
// Register map (word offsets within the window, address[1:0] ignored):
//   0x00 LED (RW, 5 bits)  0x04 PHOTO (RO, 2 bits)  0x08 CYCLE (RO)  0x0C SCRATCH (RW)
module mmio_responder #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0000_2000,
    parameter int          LATENCY         = 2,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    mmio_responder_if.slave       bus,
    input  logic [1:0]            photores,
    output logic [4:0]            led
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam logic [7:0]  DEB_M1  = 8'(DEBOUNCE_CYCLES - 1);
    // Window bounds are compared in 33 bits so a window near the top of the
    // address space does not wrap.
    localparam logic [32:0] BASE_LO = {1'b0, BASE_ADDRESS};
    localparam logic [32:0] BASE_HI = {1'b0, BASE_ADDRESS} + 33'd63;

    localparam logic [3:0]  OFF_LED     = 4'd0;
    localparam logic [3:0]  OFF_PHOTO   = 4'd1;
    localparam logic [3:0]  OFF_CYCLE   = 4'd2;
    localparam logic [3:0]  OFF_SCRATCH = 4'd3;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [3:0]  lat_offset;
    logic [31:0] lat_data;
    logic        lat_read;
    logic        lat_write;
    logic [31:0] cycle_snap;

    logic [4:0]  led_reg;
    logic [31:0] scratch;
    logic [31:0] cycle_count;
    logic [1:0]  photo;

    logic [1:0]  sync_1;
    logic [1:0]  sync_2;
    logic [1:0]  sync_prev;
    logic [7:0]  stab_cnt [2];

    logic [32:0] addr_ext;
    logic        request;
    logic [31:0] read_value;

    assign addr_ext = {1'b0, bus.address};
    assign bus.hit  = (addr_ext >= BASE_LO) && (addr_ext <= BASE_HI);
    assign request  = bus.hit && (bus.mem_read || bus.mem_write);

    // Stall is raised in the same cycle a hit request appears so the requester
    // holds it through acceptance, then for every WAIT cycle.
    assign bus.stall = ((state == IDLE) && request) || (state == WAIT);

    assign led = ~led_reg;

    // Access FSM plus the writable registers it commits into.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            lat_offset <= '0;
            lat_data   <= '0;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            cycle_snap <= '0;
            led_reg    <= '0;
            scratch    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state      <= WAIT;
                        wait_cnt   <= LAT_M1;
                        lat_offset <= bus.address[5:2];
                        lat_data   <= bus.input_data;
                        lat_read   <= bus.mem_read;
                        lat_write  <= bus.mem_write;
                        // CYCLE loads report the count at acceptance, not at completion.
                        cycle_snap <= cycle_count;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= DONE;
                        if (lat_write) begin
                            case (lat_offset)
                                OFF_LED:     led_reg <= lat_data[4:0];
                                OFF_SCRATCH: scratch <= lat_data;
                                default:     ;
                            endcase
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Two-flop synchronizer followed by a per-bit stability counter. The
    // counter restarts whenever the synchronized bit moves or already matches
    // PHOTO; PHOTO takes the new value on the edge the count reaches
    // DEBOUNCE_CYCLES-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1      <= '0;
            sync_2      <= '0;
            sync_prev   <= '0;
            photo       <= '0;
            stab_cnt[0] <= '0;
            stab_cnt[1] <= '0;
        end else begin
            sync_1    <= photores;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            for (int i = 0; i < 2; i++) begin
                if ((sync_2[i] == photo[i]) || (sync_2[i] != sync_prev[i])) begin
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 8'd1;
                    if ((stab_cnt[i] + 8'd1) >= DEB_M1) begin
                        photo[i] <= sync_2[i];
                    end
                end
            end
        end
    end

    // Load data is only presented in DONE for pure loads; a simultaneous
    // read+write behaves as a store and returns zero.
    always_comb begin
        read_value = '0;
        case (lat_offset)
            OFF_LED:     read_value = {27'd0, led_reg};
            OFF_PHOTO:   read_value = {30'd0, photo};
            OFF_CYCLE:   read_value = cycle_snap;
            OFF_SCRATCH: read_value = scratch;
            default:     read_value = '0;
        endcase
        bus.output_data = '0;
        if ((state == DONE) && lat_read && !lat_write) begin
            bus.output_data = read_value;
        end
    end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h0000_2000: byte base of the 64-byte peripheral window.
REQ-002 Parameter LATENCY, default 2: stall cycles per access, legal range 1..15.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a photores change, legal range 1..255.
REQ-004 Port clock, input, 1: single clock, all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high.
REQ-006 Port address, input, 32: byte address of the request.
REQ-007 Port input_data, input, 32: store data.
REQ-008 Port mem_read, input, 1: load request.
REQ-009 Port mem_write, input, 1: store request.
REQ-010 Port output_data, output, 32: load data, valid only in DONE.
REQ-011 Port stall, output, 1: requester must hold address, input_data, mem_read and mem_write stable while high.
REQ-012 Port hit, output, 1: combinational; address is inside [BASE_ADDRESS, BASE_ADDRESS+63].
REQ-013 Port photores, input, 2: asynchronous light-sensor bits.
REQ-014 Port led, output, 5: active-low LED drive.

Function
REQ-015 Register map, offsets address[5:0]: 0x00 LED (RW, 5 bits, upper bits read 0); 0x04 PHOTO (RO, debounced 2 bits, upper bits 0); 0x08 CYCLE (RO, 32 bits); 0x0C SCRATCH (RW, 32 bits); 0x10-0x3F unmapped.
REQ-016 address[1:0] is ignored; accesses are word-wide.
REQ-017 FSM states: IDLE, WAIT, DONE.
REQ-018 IDLE -> WAIT when hit && (mem_read || mem_write); the request is latched on that edge and wait counter loads LATENCY-1.
REQ-019 stall is combinationally 1 in IDLE whenever a hit request is present, and 1 throughout WAIT; it is 0 in DONE and for non-hit traffic.
REQ-020 WAIT decrements the counter each cycle; WAIT -> DONE when the counter is 0, giving exactly LATENCY stall cycles before DONE.
REQ-021 Stores commit on the WAIT -> DONE edge using the latched data.
REQ-022 In DONE, output_data holds the register value as of request acceptance for CYCLE, and the current value for all other offsets; otherwise output_data is 0.
REQ-023 DONE -> IDLE unconditionally after one cycle; a request present in that IDLE cycle is a new access.
REQ-024 mem_read and mem_write both high: the store is performed and output_data in DONE is 0.
REQ-025 Unmapped offsets and stores to PHOTO or CYCLE complete the full handshake; stores are discarded and loads return 0.
REQ-026 Non-hit requests cause no state change, no stall and output_data 0.
REQ-027 led = ~LED register, continuously.
REQ-028 CYCLE increments by 1 every clock and wraps from 32'hFFFF_FFFF to 0.
REQ-029 photores passes through a 2-flop synchronizer per bit.
REQ-030 Each bit has an 8-bit stability counter. The counter resets to 0 whenever the synchronized bit equals PHOTO or changes from its previous synchronized value. Otherwise it increments. PHOTO updates to the synchronized bit when the count reaches DEBOUNCE_CYCLES-1.

Reset
REQ-031 On reset: FSM enters IDLE; stall=0; output_data=0; LED=5'h00, so led=5'h1F; SCRATCH=0; CYCLE=0; PHOTO=2'b00; synchronizers and stability counters are 0.
REQ-032 Reset asserted in WAIT aborts the access, and the pending store does not commit.
REQ-033 reset has priority over every other input in the same cycle.

Verification
REQ-034 LATENCY=2: store 32'h15 to BASE+0x00 -> stall high for 2 cycles, DONE on 3rd, led=5'b01010 the cycle after DONE entry; a subsequent load returns 32'h15.
REQ-035 Store 32'hDEADBEEF to BASE+0x0C, then load -> output_data=32'hDEADBEEF in DONE; load of BASE+0x20 -> 0, stall pattern identical.
REQ-036 Load at BASE+0x40 and at BASE-4 -> hit=0, stall=0, output_data=0, no register change.
REQ-037 Set photores=2'b01 and hold -> PHOTO reads 2'b01 after 2 synchronizer plus DEBOUNCE_CYCLES cycles; a 3-cycle glitch on bit1 leaves PHOTO unchanged.
REQ-038 Start store of 32'h3 to LED, assert reset in the first WAIT cycle -> next cycle IDLE, stall=0, led=5'h1F, and no DONE occurs.
REQ-039 Force CYCLE to 32'hFFFF_FFFE through a bench hierarchical deposit, wait 2 cycles -> CYCLE=0; the load returns the value captured at acceptance.
